m4_rr_arbiter: RTL and testbench
================================

// Module: m4_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares the 4-to-1 mux (m4) between four requesters.
//   - Accepts one request line per mux input.
//   - Issues a one-hot grant and drives the m4 select pair sel1/sel2 so that out
//     carries the granted requester's input.
//   - A hold limit stops one requester from monopolising the mux.
// PARAMETERS
//   MAX_HOLD  8  max consecutive cycles one grant may last while others wait; 0 = unlimited
//   CW        4  width of hold counter; must satisfy 2**CW > MAX_HOLD
// PORTS
//   clk       in   1  clock, all state updates on rising edge
//   rst_n     in   1  reset, synchronous, active-low
//   req       in   4  request; req[0]->i1, req[1]->i2, req[2]->i3, req[3]->i4
//   gnt       out  4  one-hot grant, registered; all-zero when idle
//   sel1      out  1  m4 select MSB, registered
//   sel2      out  1  m4 select LSB, registered
//   busy      out  1  |gnt
//   hold_cnt  out  CW cycles the current grant has been held (0 when idle)
// BEHAVIOUR
//   - Select map: {sel1,sel2} = 00->i1, 01->i2, 10->i3, 11->i4.
//     Output follows gnt index, same cycle as gnt.
//   - Reset (rst_n=0 at a clk edge): gnt=0, sel1=0, sel2=0, busy=0, hold_cnt=0,
//     state=IDLE, rr pointer=3 (so req[0] wins first).
//     Reset mid-grant drops gnt on that edge.
//   - FSM IDLE:
//     - If req!=0, pick the winner, gnt=onehot(winner), hold_cnt=1, go to GRANT.
//     - Else stay in IDLE.
//   - FSM GRANT (owner k):
//     a) req[k]=1 and (MAX_HOLD==0 or hold_cnt<MAX_HOLD): keep gnt, hold_cnt++
//        (saturating at 2**CW-1).
//     b) req[k]=0, or hold expired (hold_cnt==MAX_HOLD) with another req pending:
//        - Re-arbitrate on the same edge among req with bit k masked.
//        - If there is a winner, switch directly (no idle bubble), hold_cnt=1.
//        - If none, go to IDLE with gnt=0 and hold_cnt=0.
//     c) Hold expired and no other req pending: keep grant, hold_cnt stays MAX_HOLD.
//   - Winner search: start at (ptr+1) mod 4, first set bit wins.
//     ptr updates to winner index on each new grant.
//   - Latency: req rise to gnt is 1 clk; req[k] fall to gnt[k] fall is 1 clk.
//   - gnt is always one-hot or zero; never more than one bit set.
//   - Requests that rise and fall between edges are not seen.
// CONFIGURATION
//   M4ARB_PARK_EN
//     - Defined: in IDLE, sel1/sel2 hold the last granted index (mux parked on
//       last owner); reset value is still 00.
//     - Undefined: sel1/sel2 return to 00 whenever gnt=0.
//     - gnt, busy and hold_cnt are identical in both builds.
// TESTING
//   1. rst_n=0 for 2 clk with req=4'b1111 -> gnt=0, sel=00, busy=0.
//      Release rst_n -> next clk gnt=0001, sel=00.
//   2. req=4'b0100 single pulse of 3 clk -> gnt=0100, sel=10 for 3 clk, then
//      gnt=0; sel=00 (park off) or sel=10 (M4ARB_PARK_EN).
//   3. req=1111 steady, MAX_HOLD=8 -> grant rotates 0001,0010,0100,1000,0001,
//      each held exactly 8 clk, no zero-gnt cycles between owners.
//   4. Owner req[1] drops while req[3] held -> next clk gnt=1000, sel=11,
//      hold_cnt=1 (direct handoff).
//   5. req=0001 held 20 clk, others 0 -> gnt stays 0001, hold_cnt saturates at 8.
//      Then req[2] rises -> 1 clk later gnt=0100.
//   6. Assert rst_n=0 during grant of req[3] -> gnt=0 on that edge; after release
//      with req=1000 -> gnt=1000 on the next clk.
//   Checker: connect m4, drive i1..i4 with distinct patterns, and confirm out
//   equals the granted input every cycle.

Source files
------------

// File: rtl/m4_rr_arbiter_if.sv
// Request/grant bundle between the four m4 requesters and the round-robin arbiter.
// master = requester side (drives req), slave = arbiter side (drives grant and select).
interface m4_rr_arbiter_if #(
    parameter int CW = 4
);
    logic [3:0]    req;
    logic [3:0]    gnt;
    logic          sel1;
    logic          sel2;
    logic          busy;
    logic [CW-1:0] hold_cnt;

    modport master (output req, input gnt, input sel1, input sel2, input busy, input hold_cnt);
    modport slave  (input req, output gnt, output sel1, output sel2, output busy, output hold_cnt);
endinterface

// File: rtl/m4_rr_arbiter.sv
// Round-robin arbiter sharing the 4-to-1 mux m4 between four requesters, with a hold limit.
// Optional build macro M4ARB_PARK_EN: when idle, sel1/sel2 stay parked on the last owner.
module m4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    m4_rr_arbiter_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

    localparam logic [CW-1:0] MAX_C = CW'(MAX_HOLD);
    localparam logic [CW-1:0] SAT_C = {CW{1'b1}};

    state_e        state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    ptr_q, ptr_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] hold_q, hold_d;

    logic [3:0]    cand_s;
    logic [2:0]    win_s;
    logic          keep_s;
    logic          own_s;
    logic          others_s;
    logic          expired_s;

    // First set bit of r searching upward from p+1; the pointer position itself ranks last.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = p + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state: keep, rotate or release the grant; ptr doubles as the current owner index.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        keep_s    = 1'b0;
        cand_s    = bus.req;
        own_s     = bus.req[ptr_q];
        others_s  = |(bus.req & ~(4'b0001 << ptr_q));
        expired_s = (MAX_HOLD != 0) && (hold_q >= MAX_C);
        case (state_q)
            IDLE: begin
                cand_s = bus.req;
            end
            GRANT: begin
                if (own_s && !expired_s) begin
                    keep_s = 1'b1;
                    hold_d = (hold_q == SAT_C) ? hold_q : hold_q + {{(CW-1){1'b0}}, 1'b1};
                end else if (own_s && !others_s) begin
                    keep_s = 1'b1;
                end else begin
                    cand_s = bus.req & ~(4'b0001 << ptr_q);
                end
            end
            default: begin
                cand_s = 4'b0000;
            end
        endcase

        win_s = pick(cand_s, ptr_q);
        if (keep_s) begin
            state_d = GRANT;
        end else if (win_s[2]) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << win_s[1:0];
            ptr_d   = win_s[1:0];
            hold_d  = {{(CW-1){1'b0}}, 1'b1};
        end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            hold_d  = {CW{1'b0}};
        end

        busy_d = |gnt_d;
        if (gnt_d != 4'b0000) begin
            sel_d = ptr_d;
        end else begin
`ifdef M4ARB_PARK_EN
            sel_d = sel_q;
`else
            sel_d = 2'b00;
`endif
        end
    end

    // State and registered outputs; rr pointer resets to 3 so req[0] is searched first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            ptr_q   <= 2'd3;
            busy_q  <= 1'b0;
            hold_q  <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.sel1     = sel_q[1];
    assign bus.sel2     = sel_q[0];
    assign bus.busy     = busy_q;
    assign bus.hold_cnt = hold_q;
endmodule

// File: tb/tb_m4_rr_arbiter.sv
// Scoreboard bench for m4_rr_arbiter: directed requests push hand-computed expectations,
// a monitor pops and compares them one clock later, and also checks the m4 mux output.
module tb_m4_rr_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic [3:0] hold;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       e_m;
    logic [1:0] last_sel;
    logic [7:0] in_s [4];
    logic [7:0] mux_out_s;
    logic [7:0] want_out_s;

    m4_rr_arbiter_if #(.CW(4)) bus();

    m4_rr_arbiter #(.MAX_HOLD(8), .CW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Distinct, changing data on the four mux inputs.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 4; k++) begin
            in_s[k] <= 8'((cyc * 7 + k * 64) ^ 8'h5A);
        end
    end

    function automatic logic [1:0] oh_idx(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic cmp(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Drive one cycle of stimulus and queue what the outputs must be after the next edge.
    task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] eg, input int eh);
        exp_t e;
        @(negedge clk);
        rst_n   = rst;
        bus.req = r;
        if (eg != 4'b0000) begin
            last_sel = oh_idx(eg);
        end else if (!rst) begin
            last_sel = 2'b00;
        end
        e.gnt  = eg;
        e.busy = (eg != 4'b0000);
        e.hold = 4'(eh);
`ifdef M4ARB_PARK_EN
        e.sel = last_sel;
`else
        e.sel = (eg != 4'b0000) ? oh_idx(eg) : 2'b00;
`endif
        sb_q.push_back(e);
    endtask

    // Monitor: compare registered outputs shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            e_m = sb_q.pop_front();
            cmp("gnt", int'(bus.gnt), int'(e_m.gnt));
            cmp("sel", int'({bus.sel1, bus.sel2}), int'(e_m.sel));
            cmp("busy", int'(bus.busy), int'(e_m.busy));
            cmp("hold_cnt", int'(bus.hold_cnt), int'(e_m.hold));
            cmp("onehot", int'($countones(bus.gnt) <= 1), 1);
            if (bus.gnt != 4'b0000) begin
                mux_out_s  = in_s[{bus.sel1, bus.sel2}];
                want_out_s = in_s[oh_idx(bus.gnt)];
                cmp("m4_out", int'(mux_out_s), int'(want_out_s));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        last_sel = 2'b00;

        // Reset held with all requests up, then release and rotate.
        step(1'b0, 4'b1111, 4'b0000, 0);
        step(1'b0, 4'b1111, 4'b0000, 0);
        for (int o = 0; o < 5; o++) begin
            for (int h = 1; h <= 8; h++) begin
                step(1'b1, 4'b1111, 4'b0001 << (o % 4), h);
            end
        end

        // Single requester pulse of 3 clocks, then idle.
        step(1'b1, 4'b0100, 4'b0100, 1);
        step(1'b1, 4'b0100, 4'b0100, 2);
        step(1'b1, 4'b0100, 4'b0100, 3);
        step(1'b1, 4'b0000, 4'b0000, 0);
        step(1'b1, 4'b0000, 4'b0000, 0);

        // Owner req[1] drops while req[3] waits: direct handoff.
        step(1'b1, 4'b0010, 4'b0010, 1);
        step(1'b1, 4'b1010, 4'b0010, 2);
        step(1'b1, 4'b1000, 4'b1000, 1);
        step(1'b1, 4'b0000, 4'b0000, 0);

        // Lone requester saturates at MAX_HOLD, then yields to a newcomer.
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 4'b0001, 4'b0001, (i < 8) ? i : 8);
        end
        step(1'b1, 4'b0101, 4'b0100, 1);
        step(1'b1, 4'b0100, 4'b0100, 2);

        // Reset in the middle of req[3]'s grant.
        step(1'b1, 4'b1000, 4'b1000, 1);
        step(1'b1, 4'b1000, 4'b1000, 2);
        step(1'b0, 4'b1000, 4'b0000, 0);
        step(1'b1, 4'b1000, 4'b1000, 1);
        step(1'b1, 4'b0000, 4'b0000, 0);

        for (int w = 0; w < 10 && sb_q.size() > 0; w++) begin
            @(posedge clk);
            #2;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
